// File: rtl/fir_chan_sched.sv
// Channel scheduler for the shared decimating FIR core: serialises wide input
// frames into per-channel tagged beats and re-registers the core's results.
module fir_chan_sched #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 8,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata,
  output logic                           core_tvalid,
  input  logic                           core_tready,
  output logic [DATA_WIDTH-1:0]          core_tdata,
  output logic [$clog2(CHANNELS)-1:0]    core_tchan,
  output logic [$clog2(DECIM)-1:0]       core_tphase,
  output logic                           core_tdump,
  output logic                           core_tlast,
  input  logic                           res_tvalid,
  input  logic [OUT_WIDTH-1:0]           res_tdata,
  input  logic [$clog2(CHANNELS)-1:0]    res_tchan,
  output logic                           m_tvalid,
  output logic [OUT_WIDTH-1:0]           m_tdata,
  output logic [$clog2(CHANNELS)-1:0]    m_tchan,
  output logic                           m_tlast,
  output logic                           err_seq
);

  localparam int CW = $clog2(CHANNELS);
  localparam int PW = $clog2(DECIM);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] LAST_PH = PW'(DECIM - 1);

  typedef enum logic {IDLE, SERIAL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] frame_q [CHANNELS];
  logic [DATA_WIDTH-1:0] frame_d [CHANNELS];
  logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  core_tvalid_q, core_tvalid_d;
  logic [DATA_WIDTH-1:0] core_tdata_q, core_tdata_d;
  logic [CW-1:0]         core_tchan_q, core_tchan_d;
  logic [PW-1:0]         core_tphase_q, core_tphase_d;
  logic                  core_tdump_q, core_tdump_d;
  logic                  core_tlast_q, core_tlast_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [OUT_WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic [CW-1:0]         m_tchan_q, m_tchan_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  err_seq_q, err_seq_d;
  logic [CW-1:0]         exp_chan_q, exp_chan_d;

  logic          hs, load;
  logic [CW-1:0] nxt_ch;
  logic [PW-1:0] nxt_ph, load_ph;

  assign hs       = core_tvalid_q & core_tready;
  assign s_tready = (state_q == IDLE) | ((state_q == SERIAL) & core_tlast_q & core_tready);
  assign load     = s_tvalid & s_tready;

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    ch_cnt_d      = ch_cnt_q;
    phase_d       = phase_q;
    core_tvalid_d = core_tvalid_q;
    core_tdata_d  = core_tdata_q;
    core_tchan_d  = core_tchan_q;
    core_tphase_d = core_tphase_q;
    core_tdump_d  = core_tdump_q;
    core_tlast_d  = core_tlast_q;
    nxt_ch        = ch_cnt_q + CW'(1);
    nxt_ph        = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
    load_ph       = (state_q == SERIAL) ? nxt_ph : phase_q;

    if (state_q == SERIAL && hs) begin
      if (!core_tlast_q) begin
        ch_cnt_d     = nxt_ch;
        core_tdata_d = frame_q[nxt_ch];
        core_tchan_d = nxt_ch;
        core_tlast_d = (nxt_ch == LAST_CH);
      end else begin
        phase_d       = nxt_ph;
        state_d       = IDLE;
        core_tvalid_d = 1'b0;
        core_tdata_d  = '0;
        core_tchan_d  = '0;
        core_tphase_d = '0;
        core_tdump_d  = 1'b0;
        core_tlast_d  = 1'b0;
      end
    end

    // A load on the final handshake overrides the return to IDLE, giving gapless frames.
    if (load) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        frame_d[c] = s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
      state_d       = SERIAL;
      ch_cnt_d      = '0;
      core_tvalid_d = 1'b1;
      core_tdata_d  = s_tdata[DATA_WIDTH-1:0];
      core_tchan_d  = '0;
      core_tphase_d = load_ph;
      core_tdump_d  = (load_ph == LAST_PH);
      core_tlast_d  = 1'b0;
    end
  end

  always_comb begin
    m_tvalid_d = res_tvalid;
    m_tdata_d  = res_tdata;
    m_tchan_d  = res_tchan;
    m_tlast_d  = (res_tchan == LAST_CH);
    err_seq_d  = err_seq_q;
    exp_chan_d = exp_chan_q;
    if (res_tvalid) begin
      if (res_tchan != exp_chan_q) err_seq_d = 1'b1;
      exp_chan_d = (res_tchan == LAST_CH) ? '0 : res_tchan + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_q       <= '{default: '0};
      ch_cnt_q      <= '0;
      phase_q       <= '0;
      core_tvalid_q <= 1'b0;
      core_tdata_q  <= '0;
      core_tchan_q  <= '0;
      core_tphase_q <= '0;
      core_tdump_q  <= 1'b0;
      core_tlast_q  <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
      m_tchan_q     <= '0;
      m_tlast_q     <= 1'b0;
      err_seq_q     <= 1'b0;
      exp_chan_q    <= '0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      ch_cnt_q      <= ch_cnt_d;
      phase_q       <= phase_d;
      core_tvalid_q <= core_tvalid_d;
      core_tdata_q  <= core_tdata_d;
      core_tchan_q  <= core_tchan_d;
      core_tphase_q <= core_tphase_d;
      core_tdump_q  <= core_tdump_d;
      core_tlast_q  <= core_tlast_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tdata_q     <= m_tdata_d;
      m_tchan_q     <= m_tchan_d;
      m_tlast_q     <= m_tlast_d;
      err_seq_q     <= err_seq_d;
      exp_chan_q    <= exp_chan_d;
    end
  end

  assign core_tvalid = core_tvalid_q;
  assign core_tdata  = core_tdata_q;
  assign core_tchan  = core_tchan_q;
  assign core_tphase = core_tphase_q;
  assign core_tdump  = core_tdump_q;
  assign core_tlast  = core_tlast_q;
  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = m_tdata_q;
  assign m_tchan     = m_tchan_q;
  assign m_tlast     = m_tlast_q;
  assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Bench for fir_chan_sched: directed and random stimulus against a queue-based
// model of the beat stream, frame counter and result-sequence tracker.
module tb_fir_chan_sched;

  localparam int CH  = 16;
  localparam int DW  = 16;
  localparam int DEC = 8;
  localparam int OW  = 32;
  localparam int CW  = $clog2(CH);
  localparam int PW  = $clog2(DEC);

  logic               clk = 1'b0;
  logic               rst;
  logic               s_tvalid;
  logic               s_tready;
  logic [CH*DW-1:0]   s_tdata;
  logic               core_tvalid;
  logic               core_tready;
  logic [DW-1:0]      core_tdata;
  logic [CW-1:0]      core_tchan;
  logic [PW-1:0]      core_tphase;
  logic               core_tdump;
  logic               core_tlast;
  logic               res_tvalid;
  logic [OW-1:0]      res_tdata;
  logic [CW-1:0]      res_tchan;
  logic               m_tvalid;
  logic [OW-1:0]      m_tdata;
  logic [CW-1:0]      m_tchan;
  logic               m_tlast;
  logic               err_seq;

  fir_chan_sched #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .DECIM     (DEC),
    .OUT_WIDTH (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .core_tvalid(core_tvalid),
    .core_tready(core_tready),
    .core_tdata (core_tdata),
    .core_tchan (core_tchan),
    .core_tphase(core_tphase),
    .core_tdump (core_tdump),
    .core_tlast (core_tlast),
    .res_tvalid (res_tvalid),
    .res_tdata  (res_tdata),
    .res_tchan  (res_tchan),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tchan    (m_tchan),
    .m_tlast    (m_tlast),
    .err_seq    (err_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            ch;
    int            ph;
    bit            dump;
    bit            last;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  beat_t       q[$];
  int          fcount = 0;
  bit          fresh = 1'b1;
  bit          mv = 1'b0;
  bit          ml = 1'b0;
  bit          me = 1'b0;
  logic [OW-1:0] md = '0;
  int          mc = 0;
  int          exp_ch = 0;
  bit          last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: bound expired, queue holds %0d beats", tag, q.size());
  endtask

  task automatic check_all();
    chk("s_tready", 64'(s_tready), 64'(q.size() == 0 || (q.size() == 1 && core_tready)));
    chk("core_tvalid", 64'(core_tvalid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("core_tdata", 64'(core_tdata), 64'(q[0].d));
      chk("core_tchan", 64'(core_tchan), 64'(q[0].ch));
      chk("core_tphase", 64'(core_tphase), 64'(q[0].ph));
      chk("core_tdump", 64'(core_tdump), 64'(q[0].dump));
      chk("core_tlast", 64'(core_tlast), 64'(q[0].last));
    end else if (fresh) begin
      chk("idle_tdata", 64'(core_tdata), 64'(0));
      chk("idle_tchan", 64'(core_tchan), 64'(0));
      chk("idle_tphase", 64'(core_tphase), 64'(0));
      chk("idle_tdump", 64'(core_tdump), 64'(0));
      chk("idle_tlast", 64'(core_tlast), 64'(0));
    end
    chk("m_tvalid", 64'(m_tvalid), 64'(mv));
    if (mv) begin
      chk("m_tdata", 64'(m_tdata), 64'(md));
      chk("m_tchan", 64'(m_tchan), 64'(mc));
      chk("m_tlast", 64'(m_tlast), 64'(ml));
    end
    chk("err_seq", 64'(err_seq), 64'(me));
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_edge();
    beat_t b;
    bit    ready;
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      fcount = 0;
      fresh  = 1'b1;
      mv = 1'b0; md = '0; mc = 0; ml = 1'b0; me = 1'b0; exp_ch = 0;
    end else begin
      ready = (q.size() == 0) || (q.size() == 1 && core_tready);
      if (q.size() != 0 && core_tready) begin
        b = q.pop_front();
        if (b.last) fcount++;
      end
      if (s_tvalid && ready) begin
        last_acc = 1'b1;
        fresh    = 1'b0;
        for (int c = 0; c < CH; c++) begin
          b.d    = s_tdata[c*DW +: DW];
          b.ch   = c;
          b.ph   = fcount % DEC;
          b.dump = (b.ph == DEC - 1);
          b.last = (c == CH - 1);
          q.push_back(b);
        end
      end
      mv = res_tvalid;
      md = res_tdata;
      mc = int'(res_tchan);
      ml = (int'(res_tchan) == CH - 1);
      if (res_tvalid) begin
        if (int'(res_tchan) != exp_ch) me = 1'b1;
        exp_ch = (int'(res_tchan) + 1) % CH;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    check_all();
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < CH*DW/32; k++) s_tdata[k*32 +: 32] = $urandom;
  endtask

  task automatic drain(input int limit, input bit stall);
    int g = 0;
    s_tvalid = 1'b0;
    while (q.size() != 0 && g < limit) begin
      if (stall) core_tready = 1'($urandom_range(0, 1));
      step();
      g++;
    end
    if (q.size() != 0) timeout("drain");
  endtask

  initial begin
    logic [CH*DW-1:0] imp;
    int idx, guard, prev_t, rc;

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; core_tready = 1'b0;
    res_tvalid = 1'b0; res_tdata = '0; res_tchan = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    step();
    step();

    // Impulse frame followed by 15 zero frames, back to back with core always ready.
    imp = '0;
    imp[(CH-1)*DW +: DW] = 16'h7FFF;
    core_tready = 1'b1;
    s_tvalid = 1'b1;
    idx = 0; guard = 0; prev_t = 0;
    while (idx < 16 && guard < 400) begin
      s_tdata = (idx == 0) ? imp : '0;
      step();
      if (last_acc) begin
        if (idx > 0) chk("accept_interval", 64'(cyc - prev_t), 64'(CH));
        prev_t = cyc;
        idx++;
      end
      guard++;
    end
    if (idx < 16) timeout("impulse_frames");
    drain(100, 1'b0);
    repeat (3) step();

    // Random stalls and random frame offers; in-order results run alongside.
    rc = 0;
    for (int i = 0; i < 600; i++) begin
      s_tvalid    = ($urandom_range(0, 3) != 0);
      rand_frame();
      core_tready = 1'($urandom_range(0, 1));
      res_tvalid  = ($urandom_range(0, 2) == 0);
      res_tdata   = $urandom;
      res_tchan   = CW'(rc);
      if (res_tvalid) rc = (rc + 1) % CH;
      step();
    end
    res_tvalid = 1'b0;
    drain(500, 1'b1);
    core_tready = 1'b1;
    while (rc != 0) begin
      res_tvalid = 1'b1; res_tchan = CW'(rc); res_tdata = $urandom;
      rc = (rc + 1) % CH;
      step();
    end
    res_tvalid = 1'b0;
    step();

    // Full in-order result sweep, then an out-of-order channel.
    for (int c = 0; c < CH; c++) begin
      res_tvalid = 1'b1; res_tchan = CW'(c); res_tdata = OW'(c * 100);
      step();
    end
    res_tvalid = 1'b0;
    step();
    foreach (imp[i]) if (i < 0) imp[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      res_tvalid = 1'b1;
      res_tchan  = CW'((k == 2) ? 3 : k);
      res_tdata  = -OW'(k + 1);
      step();
    end
    res_tvalid = 1'b0;
    repeat (3) step();
    res_tvalid = 1'b1; res_tchan = 4'd4; res_tdata = 32'd7;
    step();
    res_tvalid = 1'b0;
    step();

    // Reset in the middle of a frame, with a non-zero decimation phase.
    if (fcount % DEC == 0) begin
      s_tvalid = 1'b1; rand_frame();
      step();
      drain(100, 1'b0);
    end
    s_tvalid = 1'b1; rand_frame();
    guard = 0;
    while (!last_acc && guard < 50) begin step(); guard++; end
    if (!last_acc) timeout("mid_frame_accept");
    s_tvalid = 1'b0;
    guard = 0;
    while (q.size() > CH - 5 && guard < 50) begin step(); guard++; end
    if (q.size() != CH - 5) timeout("mid_frame_reach_ch5");
    chk("pre_rst_chan", 64'(core_tchan), 64'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    s_tvalid = 1'b1; rand_frame();
    step();
    s_tvalid = 1'b0;
    chk("post_rst_first_chan", 64'(core_tchan), 64'(0));
    chk("post_rst_phase", 64'(core_tphase), 64'(0));
    drain(100, 1'b0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
